stack_op_sequencer: RTL

//  Command front-end for the 16-bit LIFO stack; sits directly upstream and drives its push/pop/data_in.

---
 rtl/stack_pkg.sv | 59 +++++
 rtl/stack_alu.sv | 36 +++
 rtl/stack_op_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack blocks: opcodes, default sizes,
// per-opcode pop/push counts and the sequencer FSM state encoding.
package stack_pkg;

    localparam int DW_DEF    = 16;
    localparam int DEPTH_DEF = 32;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSHI = 4'd1;
    localparam logic [3:0] OP_DROP  = 4'd2;
    localparam logic [3:0] OP_DUP   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_SWAP  = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_POP1,
        ST_CAP1,
        ST_POP2,
        ST_CAP2,
        ST_EXEC,
        ST_PUSH1,
        ST_PUSH2,
        ST_DONE
    } seq_state_e;

    // How many words an opcode consumes and produces; legal=0 for 10..15.
    typedef struct packed {
        logic [1:0] pops;
        logic [1:0] pushes;
        logic       legal;
    } op_cnt_t;

    function automatic op_cnt_t op_counts(input logic [3:0] op);
        op_cnt_t c;
        c = '{pops: 2'd0, pushes: 2'd0, legal: 1'b1};
        case (op)
            OP_NOP:   c = '{pops: 2'd0, pushes: 2'd0, legal: 1'b1};
            OP_PUSHI: c = '{pops: 2'd0, pushes: 2'd1, legal: 1'b1};
            OP_DROP:  c = '{pops: 2'd1, pushes: 2'd0, legal: 1'b1};
            OP_DUP:   c = '{pops: 2'd1, pushes: 2'd2, legal: 1'b1};
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                      c = '{pops: 2'd2, pushes: 2'd1, legal: 1'b1};
            OP_SWAP:  c = '{pops: 2'd2, pushes: 2'd2, legal: 1'b1};
            default:  c = '{pops: 2'd0, pushes: 2'd0, legal: 1'b0};
        endcase
        return c;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational 16-bit stack ALU: result = A op B, modulo 2^DW, no flags.
module stack_alu
    import stack_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    op,
    output logic [DW-1:0] result
);

    logic [DW-1:0] and_w;
    logic [DW-1:0] or_w;
    logic [DW-1:0] xor_w;

    for (genvar gi = 0; gi < DW; gi++) begin : g_bit
        assign and_w[gi] = a[gi] & b[gi];
        assign or_w[gi]  = a[gi] | b[gi];
        assign xor_w[gi] = a[gi] ^ b[gi];
    end

    // Select the operation; non-ALU opcodes yield zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = and_w;
            OP_OR:   result = or_w;
            OP_XOR:  result = xor_w;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Command front-end for the LIFO stack: accepts one opcode per handshake,
// pops operands, runs the ALU, pushes results and reports per command.
// Occupancy is tracked locally so illegal pops/pushes never reach the stack.
module stack_op_sequencer
    import stack_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [3:0]                cmd_op,
    input  logic [DW-1:0]             cmd_imm,
    output logic                      stk_push,
    output logic                      stk_pop,
    output logic [DW-1:0]             stk_wdata,
    input  logic [DW-1:0]             stk_top,
    output logic                      rsp_valid,
    output logic [DW-1:0]             rsp_data,
    output logic                      rsp_err,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    seq_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [DW-1:0]    imm_q, imm_d;
    logic [DW-1:0]    b_q, b_d;
    logic [DW-1:0]    res_q, res_d;
    logic             err_q, err_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    op_cnt_t          op_cnt;
    logic [DW-1:0]    alu_res;
    logic [OCC_W:0]   after_push;
    logic [OCC_W:0]   push_limit;
    logic             check_err;

    assign op_cnt = op_counts(op_q);

    // One extra bit so occupancy+pushes cannot wrap; the comparison
    // occ+pushes > DEPTH+pops avoids a subtraction that could underflow.
    assign after_push = {1'b0, occ_q} + (OCC_W+1)'(op_cnt.pushes);
    assign push_limit = (OCC_W+1)'(DEPTH) + (OCC_W+1)'(op_cnt.pops);
    assign check_err  = !op_cnt.legal
                     || (occ_q < OCC_W'(op_cnt.pops))
                     || (after_push > push_limit);

    // Operand A comes straight from the stack output in EXEC.
    stack_alu #(.DW(DW)) u_alu (
        .a      (stk_top),
        .b      (b_q),
        .op     (op_q),
        .result (alu_res)
    );

    // Ready is withheld while reset is asserted so every output reads 0.
    assign cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign occupancy = occ_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            imm_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            occ_q   <= occ_d;
        end
    end

    // Next-state, strobes and response; states an opcode does not need are skipped.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        imm_d     = imm_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        occ_d     = occ_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    imm_d   = cmd_imm;
                    err_d   = 1'b0;
                    res_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (check_err) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = ST_DONE;
                end else if (op_cnt.pops != 2'd0) begin
                    state_d = ST_POP1;
                end else if (op_cnt.pushes != 2'd0) begin
                    res_d   = imm_q;
                    state_d = ST_PUSH1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_POP1: begin
                stk_pop = 1'b1;
                state_d = ST_CAP1;
            end
            ST_CAP1: begin
                // B is the old top; DROP/DUP report it directly.
                b_d = stk_top;
                if (op_cnt.pops == 2'd2) begin
                    state_d = ST_POP2;
                end else begin
                    res_d   = stk_top;
                    state_d = (op_cnt.pushes != 2'd0) ? ST_PUSH1 : ST_DONE;
                end
            end
            ST_POP2: begin
                stk_pop = 1'b1;
                state_d = is_alu_op(op_q) ? ST_EXEC : ST_CAP2;
            end
            ST_CAP2: begin
                // SWAP: A becomes the new top and the reported value.
                res_d   = stk_top;
                state_d = ST_PUSH1;
            end
            ST_EXEC: begin
                res_d   = alu_res;
                state_d = ST_PUSH1;
            end
            ST_PUSH1: begin
                // Two-push ops lay down B first, then res_q on top.
                stk_push  = 1'b1;
                stk_wdata = (op_cnt.pushes == 2'd2) ? b_q : res_q;
                state_d   = (op_cnt.pushes == 2'd2) ? ST_PUSH2 : ST_DONE;
            end
            ST_PUSH2: begin
                stk_push  = 1'b1;
                stk_wdata = res_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_data  = err_q ? '0 : res_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (stk_pop) begin
            occ_d = occ_q - OCC_W'(1);
        end else if (stk_push) begin
            occ_d = occ_q + OCC_W'(1);
        end
    end

endmodule
